// File: rtl/e_mdu_ctrl_pkg.sv
// e_mdu_ctrl_pkg: shared definitions for the P7 E-stage multiply/divide unit.
//   - mdu_op_e    : 4-bit MDU operation codes driven by the E stage
//   - mdu_state_e : sequencer state encodings (IDLE / RUN)
//   - is_multdiv(): ops that occupy the sequencer for multiple cycles
//   - is_mul_lat(): multi-cycle ops that use the multiply latency
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu accumulate ops).
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8,
    MDU_MADD  = 4'd9,
    MDU_MADDU = 4'd10,
    MDU_MSUB  = 4'd11,
    MDU_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Accumulate codes only count as real ops when the feature is built in;
  // otherwise they fall through as no-ops.
  function automatic logic is_mul_lat(logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
             (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_multdiv(logic [3:0] op);
    return is_mul_lat(op) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_arith.sv
// e_mdu_arith: combinational 64-bit result generator for the MDU.
// Ports:
//   op_i      : mdu operation code
//   rs_i/rt_i : forwarded operands
//   hi_i/lo_i : current architectural HI/LO (accumulate base, pass-through)
//   tmp_hi_o  : result high word (product high / remainder)
//   tmp_lo_o  : result low word  (product low / quotient)
//   div0_o    : divide op with zero divisor; caller must not commit
// Optional feature macro: MDU_MADD_EN.
module e_mdu_arith
  import e_mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] tmp_hi_o,
  output logic [31:0] tmp_lo_o,
  output logic        div0_o
);

  logic [63:0] prod_s, prod_u, res;
  logic [31:0] divisor, a_abs, b_abs, q_mag, r_mag, q_s, r_s, q_u, r_u;

  always_comb begin
    prod_s  = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    prod_u  = {32'd0, rs_i} * {32'd0, rt_i};

    // Zero divisor is replaced by 1 so the dividers never see /0;
    // the result is discarded via div0_o anyway.
    div0_o  = ((op_i == MDU_DIV) || (op_i == MDU_DIVU)) && (rt_i == 32'd0);
    divisor = (rt_i == 32'd0) ? 32'd1 : rt_i;

    q_u = rs_i / divisor;
    r_u = rs_i % divisor;

    // Signed divide on magnitudes: avoids the host-level INT_MIN/-1 trap and
    // naturally yields 0x80000000 rem 0 for that case. Remainder follows the
    // dividend's sign, quotient truncates toward zero.
    a_abs = rs_i[31] ? (~rs_i + 32'd1) : rs_i;
    b_abs = divisor[31] ? (~divisor + 32'd1) : divisor;
    q_mag = a_abs / b_abs;
    r_mag = a_abs % b_abs;
    q_s   = (rs_i[31] ^ divisor[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s   = rs_i[31] ? (~r_mag + 32'd1) : r_mag;

    res = {hi_i, lo_i};
    case (op_i)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV:   res = {r_s, q_s};
      MDU_DIVU:  res = {r_u, q_u};
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {hi_i, lo_i} + prod_s;
      MDU_MADDU: res = {hi_i, lo_i} + prod_u;
      MDU_MSUB:  res = {hi_i, lo_i} - prod_s;
      MDU_MSUBU: res = {hi_i, lo_i} - prod_u;
`endif
      default:   res = {hi_i, lo_i};
    endcase
    tmp_hi_o = res[63:32];
    tmp_lo_o = res[31:0];
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage multiply/divide sequencer. Accepts one MDU op per
// issue, computes the result at issue into temp regs, holds busy for a fixed
// latency, then commits to HI/LO as busy falls.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   mdu_op         : operation code (e_mdu_ctrl_pkg::mdu_op_e)
//   start          : valid issue this cycle
//   req            : flush this cycle; blocks a new issue only
//   rs_val, rt_val : forwarded operands
//   busy           : sequencer in RUN
//   rdata          : HI for mfhi, LO for mflo, else 0 (combinational)
//   hi, lo         : architectural HI/LO
// Optional feature macro: MDU_MADD_EN (accumulate ops, multiply latency).
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic        start,
  input  logic        req,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] rdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q, tmp_hi_q, tmp_lo_q;
  logic          wen_q;   // commit enable for the running op (0 on div-by-zero)

  logic [31:0] a_hi, a_lo;
  logic        a_div0, issue, issue_md;

  e_mdu_arith u_arith (
    .op_i     (mdu_op),
    .rs_i     (rs_val),
    .rt_i     (rt_val),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .tmp_hi_o (a_hi),
    .tmp_lo_o (a_lo),
    .div0_o   (a_div0)
  );

  assign issue    = start && !req && (state_q == MDU_IDLE);
  assign issue_md = issue && is_multdiv(mdu_op);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= MDU_IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (issue_md)          state_d = MDU_RUN;
      MDU_RUN:  if (cnt_q == '0)       state_d = MDU_IDLE;
      default:                         state_d = MDU_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy  = (state_q == MDU_RUN);
    rdata = 32'd0;
    if (mdu_op == MDU_MFHI)      rdata = hi_q;
    else if (mdu_op == MDU_MFLO) rdata = lo_q;
  end

  // datapath: counter, temp result, HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      wen_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else if (state_q == MDU_RUN) begin
      if (cnt_q == '0) begin
        if (wen_q) begin
          hi_q <= tmp_hi_q;
          lo_q <= tmp_lo_q;
        end
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end else if (issue) begin
      if (issue_md) begin
        tmp_hi_q <= a_hi;
        tmp_lo_q <= a_lo;
        wen_q    <= !a_div0;
        cnt_q    <= is_mul_lat(mdu_op) ? MULT_LOAD : DIV_LOAD;
      end else if (mdu_op == MDU_MTHI) begin
        hi_q <= rs_val;
      end else if (mdu_op == MDU_MTLO) begin
        lo_q <= rs_val;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
